// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : uart_pkg
// Brief   : Shared state encoding and sizing constants for the UART frame path.
// Revision: 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        CHK  = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam logic [7:0] c_sync_byte   = 8'hAA;
    localparam int unsigned c_tmo_width  = 20;
    localparam int unsigned c_frame_len  = 4;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_timeout_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_timeout_counter
// Brief   : Idle-cycle counter; expired flags the cycle it sits on limit-1.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_timeout_counter
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = c_tmo_width
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Only meaningful while counting; a cleared/idle counter never expires.
    assign expired = enable && (r_count == (limit - WIDTH'(1)));

endmodule : uart_timeout_counter
`default_nettype wire

// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_frame_decoder
// Brief   : Assembles sync/cmd/addr/chk frames from UART bytes, valid/ready out.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_frame_decoder
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = c_sync_byte,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       cmd_ready,
    output logic [7:0] frame_cmd,
    output logic [7:0] frame_addr,
    output logic       frame_valid,
    output logic       err_checksum,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy
);

    localparam logic [c_tmo_width-1:0] c_limit = TIMEOUT_CYCLES[c_tmo_width-1:0];

    state_t     r_state;
    logic [7:0] r_cmd;
    logic [7:0] r_addr;
    logic       w_in_frame;
    logic       w_expired;
    logic       w_tmo_clear;
    logic       w_tmo_enable;

    assign w_in_frame   = (r_state == CMD) || (r_state == ADDR) || (r_state == CHK);
    assign w_tmo_enable = w_in_frame && !rx_done;
    // Clearing on expiry keeps the counter at zero once we fall back to IDLE.
    assign w_tmo_clear  = !w_in_frame || rx_done || w_expired;

    uart_timeout_counter #(
        .WIDTH (c_tmo_width)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_tmo_clear),
        .enable  (w_tmo_enable),
        .limit   (c_limit),
        .expired (w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cmd        <= 8'h00;
            r_addr       <= 8'h00;
            frame_cmd    <= 8'h00;
            frame_addr   <= 8'h00;
            frame_valid  <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rx_done && (rx_data == SYNC_BYTE)) begin
                        r_state <= CMD;
                        busy    <= 1'b1;
                    end
                end
                CMD: begin
                    if (rx_done) begin
                        r_cmd   <= rx_data;
                        r_state <= ADDR;
                    end else if (w_expired) begin
                        err_timeout <= 1'b1;
                        r_state     <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                ADDR: begin
                    if (rx_done) begin
                        r_addr  <= rx_data;
                        r_state <= CHK;
                    end else if (w_expired) begin
                        err_timeout <= 1'b1;
                        r_state     <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                CHK: begin
                    if (rx_done) begin
                        if (rx_data == (r_cmd ^ r_addr)) begin
                            frame_cmd   <= r_cmd;
                            frame_addr  <= r_addr;
                            frame_valid <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            err_checksum <= 1'b1;
                            r_state      <= IDLE;
                            busy         <= 1'b0;
                        end
                    end else if (w_expired) begin
                        err_timeout <= 1'b1;
                        r_state     <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cmd_ready) begin
                        // Hand-off frees the decoder, so a coincident byte is judged as in IDLE.
                        frame_valid <= 1'b0;
                        if (rx_done && (rx_data == SYNC_BYTE)) begin
                            r_state <= CMD;
                        end else begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else if (rx_done) begin
                        err_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    frame_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_frame_decoder
`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module  : tb_uart_frame_decoder
// Brief   : Directed self-checking bench for uart_frame_decoder.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_frame_decoder;

    localparam int unsigned c_timeout = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       cmd_ready;
    logic [7:0] frame_cmd;
    logic [7:0] frame_addr;
    logic       frame_valid;
    logic       err_checksum;
    logic       err_timeout;
    logic       err_overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int n_chk    = 0;
    int n_tmo    = 0;
    int n_ovr    = 0;

    always #5 clock = ~clock;

    uart_frame_decoder #(
        .SYNC_BYTE      (8'hAA),
        .TIMEOUT_CYCLES (c_timeout)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .cmd_ready    (cmd_ready),
        .frame_cmd    (frame_cmd),
        .frame_addr   (frame_addr),
        .frame_valid  (frame_valid),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .busy         (busy)
    );

    // Pulse counters: one increment per cycle a flag is high.
    always @(negedge clock) begin
        if (err_checksum === 1'b1) n_chk <= n_chk + 1;
        if (err_timeout  === 1'b1) n_tmo <= n_tmo + 1;
        if (err_overrun  === 1'b1) n_ovr <= n_ovr + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        checks++;
        if ({frame_cmd, frame_addr, frame_valid, err_checksum, err_timeout, err_overrun, busy} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs: got cmd=%h addr=%h v=%b ec=%b et=%b eo=%b busy=%b, want all 0",
                     frame_cmd, frame_addr, frame_valid, err_checksum, err_timeout, err_overrun, busy);
        end
        reset = 1'b0;
        tick(1);
        checks++;
        if (busy !== 1'b0 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got busy=%b valid=%b, want 0 0", busy, frame_valid);
        end
    endtask

    task automatic test_good_frame;
        int b_chk, b_tmo, b_ovr;
        b_chk = n_chk; b_tmo = n_tmo; b_ovr = n_ovr;
        cmd_ready = 1'b1;
        send_byte(8'hAA);
        send_byte(8'h10);
        send_byte(8'h20);
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL good_pre_chk: got valid=%b busy=%b, want 0 1", frame_valid, busy);
        end
        send_byte(8'h30);
        checks++;
        if (frame_valid !== 1'b1 || frame_cmd !== 8'h10 || frame_addr !== 8'h20) begin
            failures++;
            $display("FAIL good_frame: got valid=%b cmd=%h addr=%h, want 1 10 20", frame_valid, frame_cmd, frame_addr);
        end
        tick(1);
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL good_handoff: got valid=%b busy=%b, want 0 0", frame_valid, busy);
        end
        tick(1);
        checks++;
        if ((n_chk - b_chk) != 0 || (n_tmo - b_tmo) != 0 || (n_ovr - b_ovr) != 0) begin
            failures++;
            $display("FAIL good_no_errors: got chk=%0d tmo=%0d ovr=%0d pulses, want 0 0 0",
                     n_chk - b_chk, n_tmo - b_tmo, n_ovr - b_ovr);
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_bad_checksum;
        int b_chk;
        b_chk = n_chk;
        send_byte(8'hAA);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h31);
        checks++;
        if (err_checksum !== 1'b1 || frame_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_chk: got ec=%b valid=%b busy=%b, want 1 0 0", err_checksum, frame_valid, busy);
        end
        tick(2);
        checks++;
        if (err_checksum !== 1'b0 || (n_chk - b_chk) != 1) begin
            failures++;
            $display("FAIL bad_chk_pulse: got ec=%b pulses=%0d, want 0 1", err_checksum, n_chk - b_chk);
        end
    endtask

    task automatic test_garbage;
        send_byte(8'h55);
        send_byte(8'h00);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL garbage_ignored: got busy=%b, want 0", busy);
        end
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        checks++;
        if (frame_valid !== 1'b1 || frame_cmd !== 8'h01 || frame_addr !== 8'h02) begin
            failures++;
            $display("FAIL garbage_frame: got valid=%b cmd=%h addr=%h, want 1 01 02", frame_valid, frame_cmd, frame_addr);
        end
        tick(3);
        checks++;
        if (frame_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_stable: got valid=%b busy=%b, want 1 1", frame_valid, busy);
        end
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL garbage_release: got valid=%b busy=%b, want 0 0", frame_valid, busy);
        end
    endtask

    task automatic test_timeout;
        int early;
        int b_tmo;
        early = 0;
        b_tmo = n_tmo;
        send_byte(8'hAA);
        send_byte(8'h10);
        for (int k = 1; k < c_timeout; k++) begin
            tick(1);
            if (err_timeout !== 1'b0 || busy !== 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL timeout_early: got %0d bad cycles before limit, want 0", early);
        end
        tick(1);
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire: got et=%b busy=%b at cycle %0d, want 1 0", err_timeout, busy, c_timeout);
        end
        tick(2);
        checks++;
        if (err_timeout !== 1'b0 || (n_tmo - b_tmo) != 1) begin
            failures++;
            $display("FAIL timeout_pulse: got et=%b pulses=%0d, want 0 1", err_timeout, n_tmo - b_tmo);
        end
    endtask

    task automatic test_timeout_edge;
        int b_tmo;
        b_tmo = n_tmo;
        cmd_ready = 1'b1;
        send_byte(8'hAA);
        send_byte(8'h10);
        tick(c_timeout - 1);
        send_byte(8'h20);
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_edge_byte: got et=%b busy=%b, want 0 1", err_timeout, busy);
        end
        send_byte(8'h30);
        checks++;
        if (frame_valid !== 1'b1 || frame_cmd !== 8'h10 || frame_addr !== 8'h20 || (n_tmo - b_tmo) != 0) begin
            failures++;
            $display("FAIL timeout_edge_frame: got valid=%b cmd=%h addr=%h tmo=%0d, want 1 10 20 0",
                     frame_valid, frame_cmd, frame_addr, n_tmo - b_tmo);
        end
        tick(1);
        cmd_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int b_ovr;
        b_ovr = n_ovr;
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h03);
        send_byte(8'h77);
        checks++;
        if (err_overrun !== 1'b1 || frame_valid !== 1'b1 || frame_cmd !== 8'h05 || frame_addr !== 8'h06) begin
            failures++;
            $display("FAIL overrun: got eo=%b valid=%b cmd=%h addr=%h, want 1 1 05 06",
                     err_overrun, frame_valid, frame_cmd, frame_addr);
        end
        tick(1);
        checks++;
        if (err_overrun !== 1'b0 || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_pulse: got eo=%b valid=%b, want 0 1", err_overrun, frame_valid);
        end
        cmd_ready = 1'b1;
        send_byte(8'hAA);
        cmd_ready = 1'b0;
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b1 || err_overrun !== 1'b0) begin
            failures++;
            $display("FAIL handoff_sync: got valid=%b busy=%b eo=%b, want 0 1 0", frame_valid, busy, err_overrun);
        end
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        checks++;
        if (frame_valid !== 1'b1 || frame_cmd !== 8'h11 || frame_addr !== 8'h22) begin
            failures++;
            $display("FAIL next_frame: got valid=%b cmd=%h addr=%h, want 1 11 22", frame_valid, frame_cmd, frame_addr);
        end
        tick(1);
        checks++;
        if ((n_ovr - b_ovr) != 1) begin
            failures++;
            $display("FAIL overrun_count: got %0d pulses, want 1", n_ovr - b_ovr);
        end
    endtask

    task automatic test_reset_mid;
        int b_all;
        // Still holding the 11/22 frame: reset must drop it silently.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0 || frame_cmd !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold: got valid=%b busy=%b cmd=%h, want 0 0 00", frame_valid, busy, frame_cmd);
        end
        b_all = n_chk + n_tmo + n_ovr;
        send_byte(8'hAA);
        send_byte(8'h10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if ({frame_cmd, frame_addr, frame_valid, err_checksum, err_timeout, err_overrun, busy} !== 21'd0) begin
            failures++;
            $display("FAIL reset_mid: got cmd=%h addr=%h v=%b busy=%b, want all 0", frame_cmd, frame_addr, frame_valid, busy);
        end
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        checks++;
        if (frame_valid !== 1'b1 || frame_cmd !== 8'h01 || frame_addr !== 8'h02) begin
            failures++;
            $display("FAIL after_reset_frame: got valid=%b cmd=%h addr=%h, want 1 01 02", frame_valid, frame_cmd, frame_addr);
        end
        tick(1);
        checks++;
        if ((n_chk + n_tmo + n_ovr) != b_all) begin
            failures++;
            $display("FAIL reset_no_errors: got %0d error pulses, want 0", n_chk + n_tmo + n_ovr - b_all);
        end
    endtask

    initial begin
        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        cmd_ready = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_garbage();
        test_timeout();
        test_timeout_edge();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_frame_decoder
`default_nettype wire
